// File: rtl/scan_chain_target.sv
// Scan-chain target: counter, Galois LFSR and user register threaded into one 3*WIDTH-bit serial chain.
// Latency: one cycle per shift or functional update; the first bit shifted in reaches scan_output after 3*WIDTH shifts.
// Backpressure: none; scan_ck_enable=0 freezes every register, so a shift burst can pause and resume.
module scan_chain_target #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(32'h0000_0001),
  parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(32'h8020_0003)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             scan_ck_enable,
  input  logic             scan_enable,
  input  logic             scan_input,
  output logic             scan_output,
  input  logic             cnt_en,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] cnt_value,
  output logic [WIDTH-1:0] lfsr_value,
  output logic [WIDTH-1:0] user_value,
  output logic [15:0]      shift_count,
  output logic             scan_active
);

  localparam int L = 3 * WIDTH;

  logic [WIDTH-1:0] cnt, lfsr, ureg;
  logic [L-1:0]     chain;
  logic [WIDTH-1:0] lfsr_nxt;

  assign chain = {cnt, lfsr, ureg};

  // A scan load can leave the LFSR at zero, where it would lock; reload the seed instead.
  always_comb begin
    lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
    if (lfsr == '0) lfsr_nxt = LFSR_SEED;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt         <= '0;
      lfsr        <= LFSR_SEED;
      ureg        <= '0;
      shift_count <= '0;
      scan_active <= 1'b0;
    end else if (scan_ck_enable) begin
      if (scan_enable) begin
        {cnt, lfsr, ureg} <= {chain[L-2:0], scan_input};
        shift_count       <= shift_count + 16'd1;
        scan_active       <= 1'b1;
      end else begin
        cnt         <= cnt + WIDTH'(cnt_en);
        lfsr        <= lfsr_nxt;
        ureg        <= wr_en ? wr_data : ureg;
        shift_count <= '0;
        scan_active <= 1'b0;
      end
    end
  end

  assign scan_output = cnt[WIDTH-1];
  assign cnt_value   = cnt;
  assign lfsr_value  = lfsr;
  assign user_value  = ureg;

endmodule

// File: tb/tb_scan_chain_target.sv
// Scoreboard bench for scan_chain_target: a bit-queue chain model feeds expected outputs to a per-cycle monitor.
module tb_scan_chain_target;
  localparam logic [31:0] SEED = 32'h0000_0001;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        aclk = 1'b0;
  logic        areset = 1'b1, scan_ck_enable = 1'b0, scan_enable = 1'b0, scan_input = 1'b0;
  logic        cnt_en = 1'b0, wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        scan_output, scan_active;
  logic [31:0] cnt_value, lfsr_value, user_value;
  logic [15:0] shift_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        so;
    logic [31:0] c, l, u;
    logic [15:0] sc;
    logic        sa;
  } exp_t;

  exp_t sb[$];

  // Model chain as a bit queue: index 0 is the next bit to leave (cnt MSB), the back is ureg[0].
  bit m_chain[$];
  int m_sc;
  bit m_sa;

  scan_chain_target dut (
    .aclk(aclk), .areset(areset), .scan_ck_enable(scan_ck_enable), .scan_enable(scan_enable),
    .scan_input(scan_input), .scan_output(scan_output), .cnt_en(cnt_en), .wr_en(wr_en),
    .wr_data(wr_data), .cnt_value(cnt_value), .lfsr_value(lfsr_value), .user_value(user_value),
    .shift_count(shift_count), .scan_active(scan_active)
  );

  always #5 aclk = ~aclk;

  function automatic logic [31:0] word(input int k);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[31-i] = m_chain[k*32+i];
    return w;
  endfunction

  function void set_words(input logic [31:0] c, input logic [31:0] l, input logic [31:0] u);
    logic [95:0] v;
    v = {c, l, u};
    m_chain.delete();
    for (int i = 95; i >= 0; i--) m_chain.push_back(v[i]);
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, advance the model, queue the expected post-edge outputs.
  task automatic cyc(input bit rst, input bit ck, input bit se, input bit si,
                     input bit ce, input bit we, input logic [31:0] wd, output logic so_before);
    logic [31:0] c, l, u;
    exp_t e;
    @(negedge aclk);
    so_before      = scan_output;
    areset         = rst;
    scan_ck_enable = ck;
    scan_enable    = se;
    scan_input     = si;
    cnt_en         = ce;
    wr_en          = we;
    wr_data        = wd;
    if (rst) begin
      set_words('0, SEED, '0);
      m_sc = 0;
      m_sa = 1'b0;
    end else if (ck && se) begin
      void'(m_chain.pop_front());
      m_chain.push_back(si);
      m_sc = (m_sc + 1) % 65536;
      m_sa = 1'b1;
    end else if (ck) begin
      c = word(0) + (ce ? 32'd1 : 32'd0);
      l = word(1);
      if (l == 0) l = SEED;
      else l = (l >> 1) ^ (l[0] ? POLY : 32'd0);
      u = we ? wd : word(2);
      set_words(c, l, u);
      m_sc = 0;
      m_sa = 1'b0;
    end
    e.so = m_chain[0];
    e.c  = word(0);
    e.l  = word(1);
    e.u  = word(2);
    e.sc = 16'(m_sc);
    e.sa = m_sa;
    sb.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a new output state; compare it with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge aclk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("scan_output", 96'(scan_output), 96'(e.so));
        check("cnt_value", 96'(cnt_value), 96'(e.c));
        check("lfsr_value", 96'(lfsr_value), 96'(e.l));
        check("user_value", 96'(user_value), 96'(e.u));
        check("shift_count", 96'(shift_count), 96'(e.sc));
        check("scan_active", 96'(scan_active), 96'(e.sa));
      end
    end
  end

  task automatic settle();
    @(posedge aclk);
    #2;
  endtask

  initial begin
    logic        so;
    logic [95:0] stream, vin;
    set_words('0, SEED, '0);
    m_sc = 0;
    m_sa = 1'b0;

    // Reset state, then five counting functional cycles.
    cyc(1, 0, 0, 0, 0, 0, '0, so);
    settle();
    check("rst_cnt", 96'(cnt_value), 96'(0));
    check("rst_lfsr", 96'(lfsr_value), 96'(SEED));
    check("rst_so", 96'(scan_output), 96'(0));
    repeat (5) cyc(0, 1, 0, 0, 1, 0, '0, so);
    settle();
    check("func5_cnt", 96'(cnt_value), 96'(5));
    check("func5_lfsr", 96'(lfsr_value), 96'(32'hD836_0002));
    check("func5_sc", 96'(shift_count), 96'(0));

    // Write ureg, then unload the whole chain with zeros shifting in.
    cyc(1, 0, 0, 0, 0, 0, '0, so);
    cyc(0, 1, 0, 0, 0, 1, 32'hDEAD_BEEF, so);
    for (int i = 0; i < 96; i++) begin
      cyc(0, 1, 1, 0, 0, 0, '0, so);
      stream[95-i] = so;
    end
    settle();
    check("unload_stream", stream, {32'h0, 32'h8020_0003, 32'hDEAD_BEEF});
    check("unload_sc", 96'(shift_count), 96'(96));
    check("unload_zero", {cnt_value, lfsr_value, user_value}, 96'(0));

    // Load a chain image MSB-first, then one functional cycle recovers the zero LFSR.
    vin = {32'h1111_1111, 32'h0, 32'hA5A5_A5A5};
    for (int i = 0; i < 96; i++) cyc(0, 1, 1, vin[95-i], 0, 0, '0, so);
    cyc(0, 1, 0, 0, 1, 0, '0, so);
    settle();
    check("load_cnt", 96'(cnt_value), 96'(32'h1111_1112));
    check("load_lfsr", 96'(lfsr_value), 96'(SEED));
    check("load_ureg", 96'(user_value), 96'(32'hA5A5_A5A5));

    // Hold cycles inside a shift burst must be invisible, even with functional strobes raised.
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 1'($urandom), 0, 0, '0, so);
    repeat (3) cyc(0, 0, 1, 1, 1, 1, 32'hFFFF_FFFF, so);
    settle();
    check("hold_sc", 96'(shift_count), 96'(20));
    for (int i = 0; i < 30; i++) cyc(0, 1, 1, 1'($urandom), 0, 0, '0, so);

    // Randomized mix of all modes including occasional resets.
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 63) == 0), 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
          1'($urandom), 1'($urandom), $urandom, so);

    // shift_count wrap, then reset in the middle of a burst.
    cyc(1, 0, 0, 0, 0, 0, '0, so);
    for (int i = 0; i < 65537; i++) cyc(0, 1, 1, 1'($urandom), 0, 0, '0, so);
    settle();
    check("wrap_sc", 96'(shift_count), 96'(1));
    for (int i = 0; i < 40; i++) cyc(0, 1, 1, 1'($urandom), 0, 0, '0, so);
    cyc(1, 1, 1, 1, 1, 1, 32'h1234_5678, so);
    settle();
    check("midrst_regs", {cnt_value, lfsr_value, user_value}, {32'h0, SEED, 32'h0});
    check("midrst_sc", 96'({shift_count, scan_active, scan_output}), 96'(0));

    repeat (3) @(posedge aclk);
    #3;
    check("sb_drain", 96'(sb.size()), 96'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
